// File: rtl/spi_master_multi_cs_pkg.sv
// spi_master_multi_cs_pkg: shared FSM states, R/W polarity and chip-select width helper
package spi_master_multi_cs_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;
  localparam logic WR_POL_WRITE = 1'b1;
  function automatic int cs_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_master_multi_cs_sclk_gen.sv
// spi_master_multi_cs_sclk_gen: SCLK half-period generator, starts high on entry and strobes the end of each phase
module spi_master_multi_cs_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int PW = $clog2(CLK_DIV);
  logic [PW-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, act_q, act_d, wrap;
  always_comb begin
    wrap = act_q && cnt_q == PW'(CLK_DIV - 1);
    rise_stb = wrap && !lvl_q;
    fall_stb = wrap && lvl_q;
    act_d = run;
    cnt_d = (!run || !act_q || wrap) ? '0 : cnt_q + 1'b1;
    lvl_d = !run ? 1'b0 : !act_q ? 1'b1 : wrap ? !lvl_q : lvl_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      act_q <= act_d;
    end
  end
  assign sclk = lvl_q;
endmodule

// File: rtl/spi_master_multi_cs.sv
// spi_master_multi_cs: mode-0 SPI master shifting addr+data frames to one of N_CS chips with read capture
module spi_master_multi_cs
  import spi_master_multi_cs_pkg::*;
#(
  parameter int   ADDR_W  = 8,
  parameter int   DATA_W  = 16,
  parameter int   N_CS    = 2,
  parameter int   CLK_DIV = 2,
  parameter logic WR_POL  = WR_POL_WRITE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [cs_w(N_CS)-1:0]  cs_sel,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rdata_vld,
  output logic                   spi_sclk_o,
  output logic                   spi_mosi_o,
  output logic [N_CS-1:0]        spi_csb_o,
  input  logic                   spi_miso_i
);
  localparam int NB = ADDR_W + DATA_W;
  localparam int BW = $clog2(NB + 1);
  localparam int PW = $clog2(CLK_DIV);
  localparam int CSW = cs_w(N_CS);
  state_e state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [NB-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d, rdata_q, rdata_d;
  logic [CSW-1:0] cs_q, cs_d;
  logic [N_CS-1:0] csb_q, csb_d;
  logic rd_q, rd_d, bad_q, bad_d, busy_q, busy_d, done_q, done_d;
  logic err_q, err_d, vld_q, vld_d, mosi_q, mosi_d;
  logic rise, fall, ph_end, pins_on, is_rd;
  spi_master_multi_cs_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk      (clk),
    .reset    (reset),
    .run      (state_d == S_SHIFT),
    .sclk     (spi_sclk_o),
    .rise_stb (rise),
    .fall_stb (fall)
  );
  always_comb begin
    ph_end = ph_q == PW'(CLK_DIV - 1);
    is_rd = addr[ADDR_W-1] != WR_POL;
    state_d = state_q;
    ph_d = (state_q == S_IDLE || state_q == S_SHIFT || ph_end) ? '0 : ph_q + 1'b1;
    bit_d = state_q != S_SHIFT ? '0 : rise ? bit_q + 1'b1 : bit_q;
    tx_d = tx_q;
    rx_d = rx_q;
    cs_d = cs_q;
    rd_d = rd_q;
    bad_d = bad_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    vld_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        cs_d = cs_sel;
        rd_d = is_rd;
        bad_d = 32'(cs_sel) >= N_CS;
        tx_d = {addr, is_rd ? '0 : wdata};
        busy_d = 1'b1;
        state_d = 32'(cs_sel) >= N_CS ? S_GAP : S_SETUP;
      end
      S_SETUP: state_d = ph_end ? S_SHIFT : S_SETUP;
      S_SHIFT: begin
        if (fall && 32'(bit_q) >= ADDR_W) rx_d = {rx_q[DATA_W-2:0], spi_miso_i};
        if (rise) begin
          tx_d = tx_q << 1;
          state_d = 32'(bit_q) == NB - 1 ? S_HOLD : S_SHIFT;
        end
      end
      S_HOLD: state_d = ph_end ? S_GAP : S_HOLD;
      S_GAP: if (ph_end) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
        err_d = bad_q;
        vld_d = rd_q && !bad_q;
        rdata_d = (rd_q && !bad_q) ? rx_q : rdata_q;
      end
      default: state_d = S_IDLE;
    endcase
    pins_on = state_d inside {S_SETUP, S_SHIFT, S_HOLD};
    csb_d = pins_on ? ~(N_CS'(1) << cs_d) : '1;
    mosi_d = (state_d == S_SETUP || state_d == S_SHIFT) && tx_d[NB-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q <= '0;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rdata_q <= '0;
      cs_q <= '0;
      csb_q <= '1;
      rd_q <= 1'b0;
      bad_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rdata_q <= rdata_d;
      cs_q <= cs_d;
      csb_q <= csb_d;
      rd_q <= rd_d;
      bad_q <= bad_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      vld_q <= vld_d;
      mosi_q <= mosi_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign rdata_vld = vld_q;
  assign spi_mosi_o = mosi_q;
  assign spi_csb_o = csb_q;
endmodule

// File: tb/tb_spi_master_multi_cs.sv
// tb_spi_master_multi_cs: scoreboard bench for the multi-CS SPI master, default and wide/slow configurations
module tb_spi_master_multi_cs;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, busy, done, err, rdata_vld, sclk, mosi, miso;
  logic [0:0] cs_sel;
  logic [7:0] addr;
  logic [15:0] wdata, rdata, miso_val;
  logic [1:0] csb;
  logic start2, busy2, done2, err2, vld2, sclk2, mosi2, miso2;
  logic [1:0] cs2;
  logic [15:0] addr2;
  logic [7:0] wdata2, rdata2;
  logic [2:0] csb2;
  int n_cmp = 0, n_bad = 0, rises = 0;
  typedef struct {
    logic [23:0] mosi;
    logic [2:0]  low;
    int          busy_len;
    int          rises;
    logic        err;
    logic        vld;
    logic [15:0] rdata;
  } exp_t;
  exp_t q1[$], q2[$];
  spi_master_multi_cs dut (
    .clk(clk), .reset(reset), .start(start), .cs_sel(cs_sel), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .rdata_vld(rdata_vld),
    .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_csb_o(csb), .spi_miso_i(miso)
  );
  spi_master_multi_cs #(.ADDR_W(16), .DATA_W(8), .N_CS(3), .CLK_DIV(5)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .cs_sel(cs2), .addr(addr2), .wdata(wdata2),
    .busy(busy2), .done(done2), .err(err2), .rdata(rdata2), .rdata_vld(vld2),
    .spi_sclk_o(sclk2), .spi_mosi_o(mosi2), .spi_csb_o(csb2), .spi_miso_i(miso2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask
  task automatic push1(input logic [23:0] mo, input logic [2:0] lo, input logic v, input logic [15:0] rd);
    q1.push_back('{mo, lo, 102, 24, 1'b0, v, rd});
  endtask
  task automatic issue(input logic c, input logic [7:0] a, input logic [15:0] w, input logic [15:0] m);
    int t = 0;
    while (busy && t < 5000) begin @(posedge clk); #1; t++; end
    if (busy) miss("issue_timeout");
    miso_val = m;
    cs_sel = c;
    addr = a;
    wdata = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic issue2(input logic [1:0] c, input logic [15:0] a, input logic [7:0] w);
    int t = 0;
    while (busy2 && t < 5000) begin @(posedge clk); #1; t++; end
    if (busy2) miss("issue2_timeout");
    cs2 = c;
    addr2 = a;
    wdata2 = w;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask
  task automatic drain(input bit second);
    int t = 0;
    while ((second ? (busy2 || q2.size() != 0) : (busy || q1.size() != 0)) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 5000) miss(second ? "drain2_timeout" : "drain1_timeout");
  endtask
  initial begin : mon1
    logic ps;
    int blen;
    logic [23:0] acc;
    logic [2:0] low;
    exp_t e;
    ps = 0; blen = 0; acc = 0; low = 0; miso = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ps = 0; blen = 0; acc = 0; low = 0; rises = 0; miso = 0;
      end else begin
        blen += int'(busy);
        if (sclk && !ps) begin
          rises++;
          acc = {acc[22:0], mosi};
          if (rises > 8) miso = miso_val[24-rises];
        end
        low |= {1'b0, ~csb};
        if (csb == 2'b00) miss("csb_single_low");
        if (done) begin
          if (q1.size() == 0) miss("unexpected_done");
          else begin
            e = q1.pop_front();
            chk("mosi_frame", 32'(acc), 32'(e.mosi));
            chk("sclk_rises", rises, e.rises);
            chk("busy_len", blen, e.busy_len);
            chk("csb_low_mask", 32'(low), 32'(e.low));
            chk("err", 32'(err), 32'(e.err));
            chk("rdata_vld", 32'(rdata_vld), 32'(e.vld));
            if (e.vld) chk("rdata", 32'(rdata), 32'(e.rdata));
          end
          blen = 0; acc = 0; low = 0; rises = 0;
        end else if (err || rdata_vld) miss("stray_pulse");
        ps = sclk;
      end
    end
  end
  initial begin : mon2
    logic ps;
    int blen, r, hi;
    logic [23:0] acc;
    logic [2:0] low;
    exp_t e;
    ps = 0; blen = 0; r = 0; hi = 0; acc = 0; low = 0; miso2 = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        blen += int'(busy2);
        if (sclk2) hi++;
        if (sclk2 && !ps) begin
          r++;
          acc = {acc[22:0], mosi2};
        end
        if (!sclk2 && ps) begin
          chk("sclk_high_len", hi, 5);
          hi = 0;
        end
        low |= ~csb2;
        if ($countones(~csb2) > 1) miss("csb2_single_low");
        if (done2) begin
          if (q2.size() == 0) miss("unexpected_done2");
          else begin
            e = q2.pop_front();
            chk("mosi_frame2", 32'(acc), 32'(e.mosi));
            chk("sclk_rises2", r, e.rises);
            chk("busy_len2", blen, e.busy_len);
            chk("csb_low_mask2", 32'(low), 32'(e.low));
            chk("err2", 32'(err2), 32'(e.err));
            chk("rdata_vld2", 32'(vld2), 32'(e.vld));
            if (e.vld) chk("rdata2", 32'(rdata2), 32'(e.rdata));
          end
          blen = 0; acc = 0; low = 0; r = 0;
        end else if (err2 || vld2) miss("stray_pulse2");
        ps = sclk2;
      end
    end
  end
  initial begin
    int t, lat;
    reset = 1; start = 0; cs_sel = 0; addr = 0; wdata = 0; miso_val = 0;
    start2 = 0; cs2 = 0; addr2 = 0; wdata2 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rdata_vld", 32'(rdata_vld), 0);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_csb", 32'(csb), 32'h3);
    reset = 0;
    push1(24'h85A53C, 3'b001, 1'b0, 16'h0);
    issue(1'b0, 8'h85, 16'hA53C, 16'hFFFF);
    chk("busy_on_accept", 32'(busy), 1);
    chk("csb_setup", 32'(csb), 32'h2);
    chk("mosi_setup_msb", 32'(mosi), 1);
    chk("sclk_setup", 32'(sclk), 0);
    push1(24'h050000, 3'b010, 1'b1, 16'h1234);
    issue(1'b1, 8'h05, 16'hFFFF, 16'h1234);
    push1(24'hC00F0F, 3'b010, 1'b0, 16'h0);
    issue(1'b1, 8'hC0, 16'h0F0F, 16'h5555);
    for (int k = 0; k < 5; k++) begin
      repeat (7) @(posedge clk);
      #1;
      cs_sel = 1'b0; addr = 8'h01; wdata = 16'hFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    drain(1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("no_queued_frame", 32'(busy), 0);
    chk("rdata_held_on_write", 32'(rdata), 32'h1234);
    issue(1'b0, 8'h85, 16'h1111, 16'h0);
    t = 0;
    while (rises < 11 && t < 500) begin @(posedge clk); #1; t++; end
    if (rises < 11) miss("bit10_timeout");
    reset = 1;
    @(posedge clk); #1;
    chk("abort_csb", 32'(csb), 32'h3);
    chk("abort_sclk", 32'(sclk), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_rdata_cleared", 32'(rdata), 0);
    reset = 0;
    push1(24'h7F0000, 3'b001, 1'b1, 16'hBEEF);
    issue(1'b0, 8'h7F, 16'hABCD, 16'hBEEF);
    drain(1'b0);
    q2.push_back('{24'h80015A, 3'b100, 5 * (2 * 24 + 3), 24, 1'b0, 1'b0, 16'h0});
    issue2(2'd2, 16'h8001, 8'h5A);
    drain(1'b1);
    q2.push_back('{24'h0, 3'b000, 5, 0, 1'b1, 1'b0, 16'h0});
    issue2(2'd3, 16'h8001, 8'h00);
    lat = 1;
    while (!done2 && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("err_done_latency", lat, 6);
    drain(1'b1);
    chk("sb1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
